// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad entry block: field widths, key codes,
// action codes, entry-state encoding and the saturating decimal accumulator.
package atm_pkg;

  localparam int unsigned PIN_SIZE     = 4;
  localparam int unsigned ACCOUNT_SIZE = 12;
  localparam int unsigned BALANCE_SIZE = 16;

  localparam logic [4:0] KEY_ENTER  = 5'h10;
  localparam logic [4:0] KEY_CLEAR  = 5'h11;
  localparam logic [4:0] KEY_CANCEL = 5'h12;

  localparam logic [2:0] ACT_BALANCE    = 3'd3;
  localparam logic [2:0] ACT_WITHDRAW   = 3'd4;
  localparam logic [2:0] ACT_DEPOSIT    = 3'd5;
  localparam logic [2:0] ACT_TRANSFER   = 3'd6;
  localparam logic [2:0] ACT_PIN_CHANGE = 3'd7;

  // Maximum digits each field will absorb before further digits are dropped.
  localparam logic [2:0] ACC_DIGITS    = 3'd3;
  localparam logic [2:0] PIN_DIGITS    = 3'd1;
  localparam logic [2:0] AMOUNT_DIGITS = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StAcc,
    StPin,
    StAction,
    StAmount,
    StDest,
    StNewPin,
    StDone
  } entry_state_e;

  function automatic logic [BALANCE_SIZE-1:0] amount_append(
    input logic [BALANCE_SIZE-1:0] cur,
    input logic [3:0]              digit
  );
    logic [BALANCE_SIZE+3:0] wide;
    wide = ({4'd0, cur} * (BALANCE_SIZE + 4)'(10)) + (BALANCE_SIZE + 4)'(digit);
    if (wide[BALANCE_SIZE+3:BALANCE_SIZE] != 4'd0) begin
      return {BALANCE_SIZE{1'b1}};
    end
    return wide[BALANCE_SIZE-1:0];
  endfunction

endpackage

// File: rtl/atm_timeout_ctr.sv
// Idle-cycle counter: counts while enabled, flags expiry on reaching
// TIMEOUT_CYCLES-1, and returns to zero whenever cleared.
module atm_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expire = enable && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expire) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad entry sequencer: collects account, PIN, action and action-specific
// fields from key strobes and presents a request until the controller accepts it.
module atm_keypad_entry
  import atm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [4:0]              key_code,
  input  logic                    req_ready,
  output logic                    req_valid,
  output logic [ACCOUNT_SIZE-1:0] accNumber,
  output logic [PIN_SIZE-1:0]     pin,
  output logic [2:0]              action,
  output logic [BALANCE_SIZE-1:0] amount,
  output logic [ACCOUNT_SIZE-1:0] destinationAcc,
  output logic                    pinChange,
  output logic [PIN_SIZE-1:0]     newPin,
  output logic                    session_abort
);

  entry_state_e            state_q, state_d;
  logic [2:0]              digits_q, digits_d;
  logic [ACCOUNT_SIZE-1:0] acc_q, acc_d;
  logic [PIN_SIZE-1:0]     pin_q, pin_d;
  logic [2:0]              action_q, action_d;
  logic [BALANCE_SIZE-1:0] amount_q, amount_d;
  logic [ACCOUNT_SIZE-1:0] dest_q, dest_d;
  logic                    pin_change_q, pin_change_d;
  logic [PIN_SIZE-1:0]     new_pin_q, new_pin_d;
  logic                    abort_q, abort_d;

  logic       is_digit, is_enter, is_clear, is_cancel;
  logic [3:0] digit;
  logic       active, expire, have_digits;

  assign digit       = key_code[3:0];
  assign is_digit    = key_valid && !key_code[4];
  assign is_enter    = key_valid && (key_code == KEY_ENTER);
  assign is_clear    = key_valid && (key_code == KEY_CLEAR);
  assign is_cancel   = key_valid && (key_code == KEY_CANCEL);
  assign have_digits = (digits_q != 3'd0);
  assign active      = (state_q != StIdle) && (state_q != StDone);

  atm_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (key_valid || !active),
    .enable(active),
    .expire(expire)
  );

  always_comb begin
    state_d      = state_q;
    digits_d     = digits_q;
    acc_d        = acc_q;
    pin_d        = pin_q;
    action_d     = action_q;
    amount_d     = amount_q;
    dest_d       = dest_q;
    pin_change_d = pin_change_q;
    new_pin_d    = new_pin_q;
    abort_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (is_digit) begin
          state_d  = StAcc;
          acc_d    = ACCOUNT_SIZE'(digit);
          digits_d = 3'd1;
        end
      end

      StAcc: begin
        if (is_digit) begin
          if (digits_q < ACC_DIGITS) begin
            acc_d    = {acc_q[ACCOUNT_SIZE-5:0], digit};
            digits_d = digits_q + 3'd1;
          end
        end else if (is_enter && have_digits) begin
          state_d  = StPin;
          digits_d = 3'd0;
        end else if (is_clear) begin
          acc_d    = '0;
          digits_d = 3'd0;
        end
      end

      StPin: begin
        if (is_digit) begin
          if (digits_q < PIN_DIGITS) begin
            pin_d    = digit;
            digits_d = 3'd1;
          end
        end else if (is_enter && have_digits) begin
          state_d  = StAction;
          digits_d = 3'd0;
        end else if (is_clear) begin
          pin_d    = '0;
          digits_d = 3'd0;
        end
      end

      StAction: begin
        if (is_digit) begin
          if (digit >= {1'b0, ACT_BALANCE} && digit <= {1'b0, ACT_PIN_CHANGE}) begin
            action_d = digit[2:0];
            digits_d = 3'd1;
          end
        end else if (is_enter && have_digits) begin
          digits_d = 3'd0;
          case (action_q)
            ACT_BALANCE:               state_d = StDone;
            ACT_WITHDRAW, ACT_DEPOSIT: state_d = StAmount;
            ACT_TRANSFER:              state_d = StDest;
            ACT_PIN_CHANGE:            state_d = StNewPin;
            default:                   state_d = StAction;
          endcase
        end else if (is_clear) begin
          action_d = '0;
          digits_d = 3'd0;
        end
      end

      StAmount: begin
        if (is_digit) begin
          if (digit <= 4'd9 && digits_q < AMOUNT_DIGITS) begin
            amount_d = amount_append(amount_q, digit);
            digits_d = digits_q + 3'd1;
          end
        end else if (is_enter && have_digits) begin
          state_d  = StDone;
          digits_d = 3'd0;
        end else if (is_clear) begin
          amount_d = '0;
          digits_d = 3'd0;
        end
      end

      StDest: begin
        if (is_digit) begin
          if (digits_q < ACC_DIGITS) begin
            dest_d   = {dest_q[ACCOUNT_SIZE-5:0], digit};
            digits_d = digits_q + 3'd1;
          end
        end else if (is_enter && have_digits) begin
          state_d  = StAmount;
          digits_d = 3'd0;
        end else if (is_clear) begin
          dest_d   = '0;
          digits_d = 3'd0;
        end
      end

      StNewPin: begin
        if (is_digit) begin
          if (digits_q < PIN_DIGITS) begin
            new_pin_d = digit;
            digits_d  = 3'd1;
          end
        end else if (is_enter && have_digits) begin
          state_d      = StDone;
          pin_change_d = 1'b1;
          digits_d     = 3'd0;
        end else if (is_clear) begin
          new_pin_d = '0;
          digits_d  = 3'd0;
        end
      end

      StDone: begin
        // Keys are ignored; account and PIN survive the handshake.
        if (req_ready) begin
          state_d      = StAction;
          digits_d     = 3'd0;
          action_d     = '0;
          amount_d     = '0;
          dest_d       = '0;
          new_pin_d    = '0;
          pin_change_d = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // A key arriving on the expiry cycle rescues the session.
    if (active && (is_cancel || (expire && !key_valid))) begin
      state_d      = StIdle;
      digits_d     = 3'd0;
      acc_d        = '0;
      pin_d        = '0;
      action_d     = '0;
      amount_d     = '0;
      dest_d       = '0;
      pin_change_d = 1'b0;
      new_pin_d    = '0;
      abort_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      digits_q     <= 3'd0;
      acc_q        <= '0;
      pin_q        <= '0;
      action_q     <= '0;
      amount_q     <= '0;
      dest_q       <= '0;
      pin_change_q <= 1'b0;
      new_pin_q    <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      digits_q     <= digits_d;
      acc_q        <= acc_d;
      pin_q        <= pin_d;
      action_q     <= action_d;
      amount_q     <= amount_d;
      dest_q       <= dest_d;
      pin_change_q <= pin_change_d;
      new_pin_q    <= new_pin_d;
      abort_q      <= abort_d;
    end
  end

  assign req_valid      = (state_q == StDone);
  assign accNumber      = acc_q;
  assign pin            = pin_q;
  assign action         = action_q;
  assign amount         = amount_q;
  assign destinationAcc = dest_q;
  assign pinChange      = pin_change_q;
  assign newPin         = new_pin_q;
  assign session_abort  = abort_q;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed and randomized checks of the keypad entry sequencer against a
// cycle-level behavioural model of the entry rules.
module tb_atm_keypad_entry;

  localparam int unsigned T = 8;

  localparam logic [4:0] K_ENT = 5'h10;
  localparam logic [4:0] K_CLR = 5'h11;
  localparam logic [4:0] K_CAN = 5'h12;

  localparam int M_IDLE = 0, M_ACC = 1, M_PIN = 2, M_ACTION = 3;
  localparam int M_AMOUNT = 4, M_DEST = 5, M_NEWPIN = 6, M_DONE = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [4:0]  key_code = 5'd0;
  logic        req_ready = 1'b0;
  logic        req_valid;
  logic [11:0] accNumber;
  logic [3:0]  pin;
  logic [2:0]  action;
  logic [15:0] amount;
  logic [11:0] destinationAcc;
  logic        pinChange;
  logic [3:0]  newPin;
  logic        session_abort;

  atm_keypad_entry #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .req_ready     (req_ready),
    .req_valid     (req_valid),
    .accNumber     (accNumber),
    .pin           (pin),
    .action        (action),
    .amount        (amount),
    .destinationAcc(destinationAcc),
    .pinChange     (pinChange),
    .newPin        (newPin),
    .session_abort (session_abort)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;

  // Behavioural model of the session.
  int          m_st = M_IDLE;
  int          m_digits = 0;
  int          m_idle = 0;
  int          m_amount = 0;
  logic [11:0] m_acc = '0;
  logic [11:0] m_dest = '0;
  logic [3:0]  m_pin = '0;
  logic [3:0]  m_newpin = '0;
  logic [2:0]  m_action = '0;
  logic        m_pc = 1'b0;
  logic        m_abort = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_clear_all();
    m_acc = '0; m_pin = '0; m_action = '0; m_amount = 0; m_dest = '0;
    m_newpin = '0; m_pc = 1'b0; m_digits = 0; m_idle = 0;
  endfunction

  function automatic void m_key(input logic [4:0] kc);
    int d;
    d = int'(kc[3:0]);
    if (kc == K_CAN) begin
      m_clear_all(); m_st = M_IDLE; m_abort = 1'b1;
    end else if (kc == K_CLR) begin
      m_digits = 0;
      case (m_st)
        M_ACC:    m_acc = '0;
        M_PIN:    m_pin = '0;
        M_ACTION: m_action = '0;
        M_AMOUNT: m_amount = 0;
        M_DEST:   m_dest = '0;
        M_NEWPIN: m_newpin = '0;
        default: ;
      endcase
    end else if (kc == K_ENT) begin
      if (m_digits > 0) begin
        m_digits = 0;
        case (m_st)
          M_ACC:    m_st = M_PIN;
          M_PIN:    m_st = M_ACTION;
          M_ACTION: m_st = (m_action == 3) ? M_DONE : (m_action == 6) ? M_DEST :
                           (m_action == 7) ? M_NEWPIN : M_AMOUNT;
          M_DEST:   m_st = M_AMOUNT;
          M_AMOUNT: m_st = M_DONE;
          M_NEWPIN: begin m_st = M_DONE; m_pc = 1'b1; end
          default: ;
        endcase
      end
    end else if (kc < 5'h10) begin
      case (m_st)
        M_ACC:    if (m_digits < 3) begin m_acc = (m_acc << 4) | 12'(d); m_digits++; end
        M_DEST:   if (m_digits < 3) begin m_dest = (m_dest << 4) | 12'(d); m_digits++; end
        M_PIN:    if (m_digits < 1) begin m_pin = 4'(d); m_digits = 1; end
        M_NEWPIN: if (m_digits < 1) begin m_newpin = 4'(d); m_digits = 1; end
        M_ACTION: if (d >= 3 && d <= 7) begin m_action = 3'(d); m_digits = 1; end
        M_AMOUNT: if (d <= 9 && m_digits < 5) begin
          m_amount = m_amount * 10 + d;
          if (m_amount > 65535) m_amount = 65535;
          m_digits++;
        end
        default: ;
      endcase
    end
  endfunction

  function automatic void model_step(input logic r, input logic kv, input logic [4:0] kc,
                                     input logic rr);
    m_abort = 1'b0;
    if (!r) begin
      m_clear_all(); m_st = M_IDLE;
    end else if (m_st == M_DONE) begin
      m_idle = 0;
      if (rr) begin
        m_st = M_ACTION; m_action = '0; m_amount = 0; m_dest = '0;
        m_newpin = '0; m_pc = 1'b0; m_digits = 0;
      end
    end else if (m_st == M_IDLE) begin
      m_idle = 0;
      if (kv && kc < 5'h10) begin
        m_st = M_ACC; m_acc = 12'(kc[3:0]); m_digits = 1;
      end
    end else if (kv) begin
      m_idle = 0;
      m_key(kc);
    end else if (m_idle == int'(T) - 1) begin
      m_clear_all(); m_st = M_IDLE; m_abort = 1'b1;
    end else begin
      m_idle++;
    end
  endfunction

  function automatic logic [63:0] dut_vec();
    return 64'({req_valid, accNumber, pin, action, amount, destinationAcc, pinChange, newPin,
                session_abort});
  endfunction

  function automatic logic [63:0] model_vec();
    return 64'({m_st == M_DONE, m_acc, m_pin, m_action, 16'(m_amount), m_dest, m_pc, m_newpin,
                m_abort});
  endfunction

  task automatic step(input logic r, input logic kv, input logic [4:0] kc, input logic rr);
    rst = r; key_valid = kv; key_code = kc; req_ready = rr;
    @(posedge clk);
    model_step(r, kv, kc, rr);
    #1;
    check("cycle", dut_vec(), model_vec());
  endtask

  task automatic key(input logic [4:0] kc);
    step(1'b1, 1'b1, kc, 1'b0);
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, rr);
  endtask

  int n_abort;
  int r;
  logic [4:0] kc;
  logic kv;

  initial begin
    // Reset
    step(1'b0, 1'b1, 5'h3, 1'b1);
    step(1'b0, 1'b0, 5'd0, 1'b0);
    check("reset_outputs", dut_vec(), 64'd0);

    // Basic deposit session
    key(5'hA); key(5'h1); key(K_ENT);
    key(5'h1); key(K_ENT);
    key(5'h5); key(K_ENT);
    key(5'h1); key(5'h2); key(5'h3); key(K_ENT);
    check("basic_valid", 64'(req_valid), 64'd1);
    check("basic_acc", 64'(accNumber), 64'h0A1);
    check("basic_pin", 64'(pin), 64'd1);
    check("basic_action", 64'(action), 64'd5);
    check("basic_amount", 64'(amount), 64'd123);
    idle(2, 1'b0);
    idle(1, 1'b1);
    check("basic_handshake_valid", 64'(req_valid), 64'd0);

    // Transfer with a stalled handshake
    key(5'h6); key(K_ENT);
    key(5'hB); key(5'h2); key(K_ENT);
    key(5'h5); key(5'h0); key(K_ENT);
    idle(10, 1'b0);
    check("xfer_valid_held", 64'(req_valid), 64'd1);
    check("xfer_dest", 64'(destinationAcc), 64'h0B2);
    check("xfer_amount", 64'(amount), 64'd50);
    idle(1, 1'b1);
    check("xfer_released", 64'(req_valid), 64'd0);
    check("xfer_acc_kept", 64'(accNumber), 64'h0A1);
    check("xfer_dest_cleared", 64'(destinationAcc), 64'd0);

    // PIN change, then balance enquiry
    key(5'h7); key(K_ENT); key(5'h9); key(K_ENT);
    check("pinchg_flag", 64'(pinChange), 64'd1);
    check("pinchg_newpin", 64'(newPin), 64'd9);
    check("pinchg_valid", 64'(req_valid), 64'd1);
    idle(1, 1'b1);
    key(5'h3); key(K_ENT);
    check("balance_valid", 64'(req_valid), 64'd1);
    check("balance_amount", 64'(amount), 64'd0);
    idle(1, 1'b1);

    // Amount saturation and digit limit
    key(5'h4); key(K_ENT);
    for (int i = 0; i < 6; i++) key(5'h9);
    check("amount_saturate", 64'(amount), 64'd65535);
    key(K_ENT);
    idle(1, 1'b1);

    // Cancel, then CLEAR inside the account field
    key(K_CAN);
    check("cancel_abort", 64'(session_abort), 64'd1);
    check("cancel_acc", 64'(accNumber), 64'd0);
    key(5'h1); key(5'h2); key(K_CLR); key(5'h3); key(K_ENT);
    check("clear_acc", 64'(accNumber), 64'h003);
    key(5'h4); key(K_ENT); key(5'h4); key(K_ENT); key(5'h7);
    step(1'b0, 1'b1, 5'h8, 1'b1);
    check("midsession_reset", dut_vec(), 64'd0);

    // Timeout abort fires exactly once
    key(5'h5);
    n_abort = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 5'd0, 1'b0);
      if (session_abort) n_abort++;
    end
    check("timeout_pulses", 64'(n_abort), 64'd1);
    check("timeout_acc", 64'(accNumber), 64'd0);

    // A key on the expiry cycle keeps the session alive
    key(5'h5);
    idle(int'(T) - 1, 1'b0);
    key(5'h5);
    check("expiry_key_no_abort", 64'(session_abort), 64'd0);
    check("expiry_key_acc", 64'(accNumber), 64'h055);
    key(K_CAN);

    // Randomized sessions
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      kv = 1'b1;
      if (r < 50)      kc = 5'($urandom_range(0, 15));
      else if (r < 55) kc = 5'($urandom_range(3, 7));
      else if (r < 70) kc = K_ENT;
      else if (r < 74) kc = K_CLR;
      else if (r < 76) kc = K_CAN;
      else if (r < 79) kc = 5'($urandom_range(19, 31));
      else begin kv = 1'b0; kc = 5'($urandom_range(0, 31)); end
      if ($urandom_range(0, 299) == 0) idle(int'(T) + 2, 1'b0);
      step(($urandom_range(0, 499) != 0), kv, kc, 1'($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/atm_keypad_entry.md
ATM_KEYPAD_ENTRY -- requirements
Module: atm_keypad_entry

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, idle cycles before session abort.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 key_valid  in  1  one-cycle strobe, key_code valid.
REQ-005 key_code  in  5  0x00-0x0F hex digit; 0x10 ENTER; 0x11 CLEAR; 0x12 CANCEL; others ignored.
REQ-006 req_ready  in  1  downstream controller accepts request.
REQ-007 req_valid  out  1  request fields complete and stable.
REQ-008 accNumber  out  12  entered account number.
REQ-009 pin  out  4  entered PIN.
REQ-010 action  out  3  selected action code (3..7).
REQ-011 amount  out  16  entered amount, decimal-converted.
REQ-012 destinationAcc  out  12  transfer destination account.
REQ-013 pinChange  out  1  high with action 7 and a captured newPin.
REQ-014 newPin  out  4  replacement PIN.
REQ-015 session_abort  out  1  one-cycle pulse on CANCEL or timeout.

Function
REQ-016 States IDLE, ACC, PIN, ACTION, AMOUNT, DEST, NEWPIN, DONE; IDLE->ACC on any accepted digit, and that digit is captured.
REQ-017 ACC/DEST: each hex digit shifts the field left one nibble, inserting the digit at the LSB. The field holds a maximum of 3 digits, and further digits are ignored.
REQ-018 PIN/NEWPIN: each hex digit overwrites the field, and the field holds a maximum of 1 digit.
REQ-019 ACTION: only digits 3-7 are accepted, each overwriting the field; other digits are ignored.
REQ-020 AMOUNT: only digits 0-9 are accepted; amount = amount*10+digit, saturating at 65535. The field holds a maximum of 5 digits, and hex digits A-F are ignored.
REQ-021 ENTER with zero digits in the current field is ignored.
REQ-022 ENTER transitions:
  - ACC->PIN and PIN->ACTION.
  - ACTION 3->DONE; 4/5->AMOUNT; 6->DEST; 7->NEWPIN.
  - DEST->AMOUNT.
  - AMOUNT->DONE and NEWPIN->DONE; NEWPIN->DONE also sets pinChange.
REQ-023 CLEAR zeroes the current field and its digit count; the state is unchanged.
REQ-024 Keys in IDLE other than digits are ignored, and all keys in DONE are ignored.
REQ-025 DONE: req_valid=1; all outputs hold stable until the cycle in which req_valid&&req_ready.
REQ-026 On handshake: next cycle state=ACTION; req_valid=0; action, amount, destinationAcc, newPin and pinChange cleared. accNumber and pin are retained, so the session continues.
REQ-027 CANCEL in any state except IDLE/DONE: next state IDLE, all fields cleared, session_abort pulses one cycle.
REQ-028 Timeout counter:
  - Cleared on every key_valid and on entry to IDLE/DONE.
  - Increments in ACC..NEWPIN.
  - Reaching TIMEOUT_CYCLES-1 behaves as CANCEL.
REQ-029 Simultaneous key_valid and timeout expiry: the key is processed and the counter is cleared, so no abort occurs.
REQ-030 Latency: field, state and output updates occur on the clock edge after key_valid; req_valid rises on the edge after the final ENTER.

Reset
REQ-031 rst=0 at a rising edge: state IDLE, all outputs 0, digit count and timeout counter 0. This applies mid-entry or mid-handshake.
REQ-032 Reset has priority over key_valid, req_ready and timeout in the same cycle.

Structure
REQ-033 Shared package atm_pkg holds:
  - PIN_SIZE=4, ACCOUNT_SIZE=12, BALANCE_SIZE=16.
  - Key-code constants.
  - Action codes 3..7.
  - Entry-state enumeration.
REQ-034 One sub-module, atm_timeout_ctr: inputs clear and enable, output expire, width derived from TIMEOUT_CYCLES.

Verification
REQ-035 Keys A,1,ENTER,1,ENTER,5,ENTER,1,2,3,ENTER -> next cycle req_valid=1, accNumber=0x0A1, pin=1, action=5, amount=123.
REQ-036 Amount keys 9,9,9,9,9,9 -> amount=65535 (saturated; sixth digit ignored).
REQ-037 Action 6, dest B,2,ENTER, amount 5,0,ENTER; hold req_ready=0 for 10 cycles -> outputs stable with destinationAcc=0x0B2, amount=50. Then req_ready=1 -> req_valid=0, state ACTION, accNumber retained.
REQ-038 Action 7 then 9,ENTER -> pinChange=1, newPin=9, req_valid=1. Action 3,ENTER -> req_valid=1, amount=0.
REQ-039 TIMEOUT_CYCLES=8, enter one account digit then idle -> session_abort pulses exactly once; state IDLE; accNumber=0.
REQ-040 CLEAR after digits 1,2 in ACC, then 3,ENTER -> accNumber=0x003. rst=0 asserted during AMOUNT -> all outputs 0 the next cycle.
